// File: rtl/mvm_out_requant.sv
// mvm_out_requant
// Output requantization and writeback staging for the MVM engine. Each
// accepted beat carries TOUT signed accumulators; every lane is rounded
// (half-up) and arithmetically shifted right, optionally ReLU'd, saturated
// to 8 or 16 bits and packed into one TOUT*MAX_DAT_DW output word. A beat
// counter flags the final word of the job with m_last.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            one-cycle job start (only honoured in IDLE)
//   cfg_shift        right-shift amount, latched on start
//   cfg_relu_en      ReLU enable, latched on start
//   cfg_dw8          1: clamp to 8 bit, 0: clamp to 16 bit, latched on start
//   cfg_pix_num      beats in the job, latched on start
//   s_valid/s_ready  accumulator beat handshake, s_data lane k at [k*ACC_DW +: ACC_DW]
//   m_valid/m_ready  packed word handshake, m_data lane k at [k*MAX_DAT_DW +: MAX_DAT_DW]
//   m_last           final word of the job
//   busy             high while the job is running
//   done             one-cycle pulse at job completion
//   sat_cnt          beats with at least one saturated lane (sticky at max)

module mvm_out_requant #(
    parameter int unsigned TOUT       = 8,
    parameter int unsigned ACC_DW     = 32,
    parameter int unsigned MAX_DAT_DW = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [4:0]                   cfg_shift,
    input  logic                         cfg_relu_en,
    input  logic                         cfg_dw8,
    input  logic [15:0]                  cfg_pix_num,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [TOUT*ACC_DW-1:0]       s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [TOUT*MAX_DAT_DW-1:0]   m_data,
    output logic                         m_last,
    output logic                         busy,
    output logic                         done,
    output logic [15:0]                  sat_cnt
);

    localparam int unsigned TW = ACC_DW + 1;
    localparam int unsigned CW = 16;

    localparam logic signed [TW-1:0] HI8  = TW'(127);
    localparam logic signed [TW-1:0] LO8  = TW'(-128);
    localparam logic signed [TW-1:0] HI16 = TW'(32767);
    localparam logic signed [TW-1:0] LO16 = TW'(-32768);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;

    logic [4:0]                    r_shift;
    logic                          r_relu;
    logic                          r_dw8;
    logic [CW-1:0]                 r_pix;
    logic [CW-1:0]                 r_in_cnt;
    logic [CW-1:0]                 r_out_cnt;
    logic [CW-1:0]                 r_ld_cnt;
    logic [CW-1:0]                 r_sat_cnt;

    logic                          r_s1_valid;
    logic signed [TW-1:0]          r_s1_t [TOUT];
    logic                          r_m_valid;
    logic [TOUT*MAX_DAT_DW-1:0]    r_m_data;
    logic                          r_m_last;

    logic                          w_en;
    logic                          w_s_hs;
    logic                          w_m_hs;
    logic [CW-1:0]                 w_pix_m1;
    logic [TW-1:0]                 w_round;
    logic signed [TW-1:0]          w_s1_t [TOUT];
    logic [TOUT*MAX_DAT_DW-1:0]    w_s2_data;
    logic                          w_any_sat;

    // Whole pipeline advances together; a stalled output word freezes both stages.
    assign w_en     = !r_m_valid || m_ready;
    assign s_ready  = w_en && (r_state == RUN) && (r_in_cnt < r_pix);
    assign w_s_hs   = s_valid && s_ready;
    assign w_m_hs   = r_m_valid && m_ready;
    assign w_pix_m1 = r_pix - CW'(1);
    assign w_round  = (r_shift == 5'd0) ? '0 : (TW'(1) << (r_shift - 5'd1));

    assign m_valid  = r_m_valid;
    assign m_data   = r_m_data;
    assign m_last   = r_m_last;
    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);
    assign sat_cnt  = r_sat_cnt;

    // S1: sign-extend by one bit so adding the rounding constant cannot overflow.
    always_comb begin
        logic signed [TW-1:0] v_sum;
        v_sum = '0;
        for (int k = 0; k < int'(TOUT); k++) begin
            v_sum     = {s_data[k*ACC_DW + ACC_DW - 1], s_data[k*ACC_DW +: ACC_DW]} + w_round;
            w_s1_t[k] = v_sum >>> r_shift;
        end
    end

    // S2: ReLU first, then clamp; only the clamp counts as saturation.
    always_comb begin
        logic signed [TW-1:0] v_t;
        logic signed [TW-1:0] v_hi;
        logic signed [TW-1:0] v_lo;
        v_t       = '0;
        v_hi      = r_dw8 ? HI8 : HI16;
        v_lo      = r_dw8 ? LO8 : LO16;
        w_any_sat = 1'b0;
        w_s2_data = '0;
        for (int k = 0; k < int'(TOUT); k++) begin
            v_t = r_s1_t[k];
            if (r_relu && v_t[TW-1]) begin
                v_t = '0;
            end
            if (v_t > v_hi) begin
                v_t       = v_hi;
                w_any_sat = 1'b1;
            end else if (v_t < v_lo) begin
                v_t       = v_lo;
                w_any_sat = 1'b1;
            end
            // Clamped value fits in 16 bits, so the low bits are already sign-extended.
            w_s2_data[k*MAX_DAT_DW +: MAX_DAT_DW] = v_t[MAX_DAT_DW-1:0];
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (cfg_pix_num == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_m_hs && (r_out_cnt == w_pix_m1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, config, counters and pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_relu     <= 1'b0;
            r_dw8      <= 1'b0;
            r_pix      <= '0;
            r_in_cnt   <= '0;
            r_out_cnt  <= '0;
            r_ld_cnt   <= '0;
            r_sat_cnt  <= '0;
            r_s1_valid <= 1'b0;
            for (int k = 0; k < int'(TOUT); k++) begin
                r_s1_t[k] <= '0;
            end
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_m_last   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_s_hs) begin
                r_in_cnt <= r_in_cnt + CW'(1);
            end
            if (w_m_hs) begin
                r_out_cnt <= r_out_cnt + CW'(1);
            end

            if (w_en) begin
                r_s1_valid <= w_s_hs;
                if (w_s_hs) begin
                    r_s1_t <= w_s1_t;
                end
                r_m_valid <= r_s1_valid;
                // Words reach S2 in order, so the load count tags the final word.
                r_m_last  <= r_s1_valid && (r_ld_cnt == w_pix_m1);
                if (r_s1_valid) begin
                    r_m_data <= w_s2_data;
                    r_ld_cnt <= r_ld_cnt + CW'(1);
                    if (w_any_sat && (r_sat_cnt != '1)) begin
                        r_sat_cnt <= r_sat_cnt + CW'(1);
                    end
                end
            end

            // Job start wins over any counter update (none can occur in IDLE anyway).
            if ((r_state == IDLE) && start) begin
                r_shift   <= cfg_shift;
                r_relu    <= cfg_relu_en;
                r_dw8     <= cfg_dw8;
                r_pix     <= cfg_pix_num;
                r_in_cnt  <= '0;
                r_out_cnt <= '0;
                r_ld_cnt  <= '0;
                r_sat_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mvm_out_requant.sv
// Directed testbench for mvm_out_requant: hand-computed vectors plus a small
// reference model for the randomised streaming scenarios.

module tb_mvm_out_requant;

    localparam int TOUT = 8;
    localparam int ACC_DW = 32;
    localparam int DW = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [4:0]            cfg_shift;
    logic                  cfg_relu_en;
    logic                  cfg_dw8;
    logic [15:0]           cfg_pix_num;
    logic                  s_valid;
    logic                  s_ready;
    logic [TOUT*ACC_DW-1:0] s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [TOUT*DW-1:0]    m_data;
    logic                  m_last;
    logic                  busy;
    logic                  done;
    logic [15:0]           sat_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Stream scoreboard state shared by run_stream and the tests.
    logic [TOUT*ACC_DW-1:0] in_beats  [256];
    logic [TOUT*DW-1:0]     exp_words [256];
    logic [TOUT*DW-1:0]     out_words [256];
    logic                   out_last  [256];
    int n_out, n_done, n_sent, stall_viol, sready_gap, extra_mvalid;
    int last_cyc, done_cyc, last_acc_cyc;

    mvm_out_requant #(.TOUT(TOUT), .ACC_DW(ACC_DW), .MAX_DAT_DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_shift(cfg_shift), .cfg_relu_en(cfg_relu_en), .cfg_dw8(cfg_dw8),
        .cfg_pix_num(cfg_pix_num),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [TOUT*ACC_DW-1:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
        int a [8];
        logic [TOUT*ACC_DW-1:0] r;
        a = '{a0, a1, a2, a3, a4, a5, a6, a7};
        r = '0;
        for (int k = 0; k < 8; k++) r[k*ACC_DW +: ACC_DW] = a[k];
        return r;
    endfunction

    function automatic logic [TOUT*DW-1:0] pw(input int a0, a1, a2, a3, a4, a5, a6, a7);
        int a [8];
        logic [TOUT*DW-1:0] r;
        a = '{a0, a1, a2, a3, a4, a5, a6, a7};
        r = '0;
        for (int k = 0; k < 8; k++) r[k*DW +: DW] = 16'(a[k]);
        return r;
    endfunction

    function automatic logic [TOUT*ACC_DW-1:0] rnd_beat();
        logic [TOUT*ACC_DW-1:0] r;
        int v;
        for (int k = 0; k < 8; k++) begin
            v = int'($urandom);
            v = v >>> $urandom_range(31, 16);
            r[k*ACC_DW +: ACC_DW] = v;
        end
        return r;
    endfunction

    // Reference requantization of one lane using 64-bit integer arithmetic.
    function automatic logic [15:0] ref_lane(input logic [31:0] acc, input int sh,
                                             input bit relu, input bit dw8, output bit sat);
        longint t, hi, lo;
        t = longint'($signed(acc));
        if (sh > 0) t = t + (longint'(1) << (sh - 1));
        t = t >>> sh;
        if (relu && t < 0) t = 0;
        hi = dw8 ? 127 : 32767;
        lo = dw8 ? -128 : -32768;
        sat = 1'b0;
        if (t > hi) begin t = hi; sat = 1'b1; end
        else if (t < lo) begin t = lo; sat = 1'b1; end
        return t[15:0];
    endfunction

    task automatic gen_rand(input int n, input int sh, input bit relu, input bit dw8, output int nsat);
        bit s, any;
        nsat = 0;
        for (int i = 0; i < n; i++) begin
            in_beats[i] = rnd_beat();
            any = 1'b0;
            for (int k = 0; k < 8; k++) begin
                exp_words[i][k*DW +: DW] = ref_lane(in_beats[i][k*ACC_DW +: ACC_DW], sh, relu, dw8, s);
                any = any | s;
            end
            if (any) nsat++;
        end
    endtask

    // Called one time unit after a rising edge; leaves the same phase after the start edge.
    task automatic start_job(input int sh, input bit relu, input bit dw8, input int pix);
        cfg_shift   = 5'(sh);
        cfg_relu_en = relu;
        cfg_dw8     = dw8;
        cfg_pix_num = 16'(pix);
        start       = 1'b1;
        s_valid     = 1'b0;
        m_ready     = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
        cfg_shift   = 5'($urandom);
        cfg_relu_en = 1'($urandom);
        cfg_dw8     = 1'($urandom);
        cfg_pix_num = 16'($urandom);
    endtask

    // Drives n_in beats with pv% valid / pr% ready, records outputs until done plus a tail.
    task automatic run_stream(input int n_in, input int pv, input int pr, input int max_cyc);
        int cyc;
        bit prev_stall;
        logic [TOUT*DW-1:0] prev_d;
        logic prev_l;
        cyc = 0; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
        n_out = 0; n_done = 0; n_sent = 0; stall_viol = 0; sready_gap = 0; extra_mvalid = 0;
        last_cyc = -1; done_cyc = -1; last_acc_cyc = -1;
        while (cyc < max_cyc && n_done == 0) begin
            s_valid = (n_sent < n_in) && (int'($urandom_range(99)) < pv);
            s_data  = s_valid ? in_beats[n_sent] : rnd_beat();
            m_ready = (int'($urandom_range(99)) < pr);
            #1;
            if (done) begin n_done++; done_cyc = cyc; end
            if (prev_stall && (m_data !== prev_d || m_last !== prev_l || m_valid !== 1'b1)) stall_viol++;
            prev_stall = m_valid && !m_ready;
            prev_d = m_data;
            prev_l = m_last;
            if (busy && n_sent < n_in && !s_ready) sready_gap++;
            if (s_valid && s_ready) begin last_acc_cyc = cyc; n_sent++; end
            if (m_valid && m_ready) begin
                if (n_out < 256) begin
                    out_words[n_out] = m_data;
                    out_last[n_out]  = m_last;
                end
                if (m_last) last_cyc = cyc;
                n_out++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (done) n_done++;
            if (m_valid) extra_mvalid++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; m_ready = 1'b1; s_data = '0;
        cfg_shift = '0; cfg_relu_en = 1'b0; cfg_dw8 = 1'b0; cfg_pix_num = '0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        #1;
        if (s_ready !== 1'b0) begin $display("FAIL reset_s_ready: got %b want 0", s_ready); n_err++; end
        n_vec++;
        if (m_valid !== 1'b0) begin $display("FAIL reset_m_valid: got %b want 0", m_valid); n_err++; end
        n_vec++;
        if (m_data !== '0) begin $display("FAIL reset_m_data: got %h want 0", m_data); n_err++; end
        n_vec++;
        if (m_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL reset_flags: last/busy/done got %b%b%b want 000", m_last, busy, done); n_err++;
        end
        n_vec++;
        if (sat_cnt !== 16'd0) begin $display("FAIL reset_sat_cnt: got %0d want 0", sat_cnt); n_err++; end
        n_vec++;
    endtask

    task automatic test_rounding();
        logic [TOUT*DW-1:0] e;
        in_beats[0] = pk(100, -100, 48, -48, 0, 31, 32, 1000);
        e = pw(3, -3, 2, -1, 0, 1, 1, 31);
        start_job(5, 1'b0, 1'b1, 1);
        run_stream(1, 100, 100, 50);
        if (n_out !== 1) begin $display("FAIL round_count: got %0d want 1", n_out); n_err++; end
        n_vec++;
        if (out_words[0] !== e) begin $display("FAIL round_data: got %h want %h", out_words[0], e); n_err++; end
        n_vec++;
        if (out_last[0] !== 1'b1) begin $display("FAIL round_last: got %b want 1", out_last[0]); n_err++; end
        n_vec++;
        if (done_cyc !== last_cyc + 1) begin
            $display("FAIL round_done_timing: done cycle %0d want %0d", done_cyc, last_cyc + 1); n_err++;
        end
        n_vec++;
        if (n_done !== 1) begin $display("FAIL round_done_count: got %0d want 1", n_done); n_err++; end
        n_vec++;
        if (sat_cnt !== 16'd0) begin $display("FAIL round_sat_cnt: got %0d want 0", sat_cnt); n_err++; end
        n_vec++;
    endtask

    task automatic test_sat_relu();
        logic [TOUT*DW-1:0] e0, e1;
        // 8-bit clamp, no ReLU: only beat 0 saturates.
        in_beats[0] = pk(200, -200, 5, -5, 127, 128, -128, -129);
        in_beats[1] = pk(-5, 10, 0, 1, -1, 2, -2, 3);
        e0 = pw(127, -128, 5, -5, 127, 127, -128, -128);
        e1 = pw(-5, 10, 0, 1, -1, 2, -2, 3);
        start_job(0, 1'b0, 1'b1, 2);
        run_stream(2, 100, 100, 50);
        if (out_words[0] !== e0) begin $display("FAIL sat8_w0: got %h want %h", out_words[0], e0); n_err++; end
        n_vec++;
        if (out_words[0][31:16] !== 16'hFF80) begin $display("FAIL sat8_neg_lane: got %h want ff80", out_words[0][31:16]); n_err++; end
        n_vec++;
        if (out_words[1] !== e1) begin $display("FAIL sat8_w1: got %h want %h", out_words[1], e1); n_err++; end
        n_vec++;
        if (out_last[0] !== 1'b0 || out_last[1] !== 1'b1) begin
            $display("FAIL sat8_last: got %b%b want 01", out_last[0], out_last[1]); n_err++;
        end
        n_vec++;
        if (sat_cnt !== 16'd1) begin $display("FAIL sat8_cnt: got %0d want 1", sat_cnt); n_err++; end
        n_vec++;
        // ReLU with 8-bit clamp: negatives become 0 and do not count as saturation.
        in_beats[0] = pk(-5, -200, 200, 7, 0, -1, 127, -300);
        in_beats[1] = pk(-5, 0, 1, -128, 128, -129, 5, -70000);
        e0 = pw(0, 0, 127, 7, 0, 0, 127, 0);
        e1 = pw(0, 0, 1, 0, 127, 0, 5, 0);
        start_job(0, 1'b1, 1'b1, 2);
        run_stream(2, 100, 100, 50);
        if (out_words[0] !== e0) begin $display("FAIL relu_w0: got %h want %h", out_words[0], e0); n_err++; end
        n_vec++;
        if (out_words[1] !== e1) begin $display("FAIL relu_w1: got %h want %h", out_words[1], e1); n_err++; end
        n_vec++;
        if (sat_cnt !== 16'd2) begin $display("FAIL relu_sat_cnt: got %0d want 2", sat_cnt); n_err++; end
        n_vec++;
        // 16-bit clamp.
        in_beats[0] = pk(70000, -70000, 32767, -32768, 32768, -32769, 200, -200);
        e0 = pw(32767, -32768, 32767, -32768, 32767, -32768, 200, -200);
        start_job(0, 1'b0, 1'b0, 1);
        run_stream(1, 100, 100, 50);
        if (out_words[0] !== e0) begin $display("FAIL sat16_w0: got %h want %h", out_words[0], e0); n_err++; end
        n_vec++;
        if (sat_cnt !== 16'd1) begin $display("FAIL sat16_cnt: got %0d want 1", sat_cnt); n_err++; end
        n_vec++;
    endtask

    task automatic test_backpressure();
        int nsat, bad_last;
        gen_rand(64, 6, 1'b0, 1'b1, nsat);
        start_job(6, 1'b0, 1'b1, 64);
        run_stream(64, 50, 50, 3000);
        if (n_out !== 64) begin $display("FAIL bp_count: got %0d want 64", n_out); n_err++; end
        n_vec++;
        for (int i = 0; i < 64 && i < n_out; i++) begin
            if (out_words[i] !== exp_words[i]) begin
                $display("FAIL bp_word%0d: got %h want %h", i, out_words[i], exp_words[i]); n_err++;
            end
            n_vec++;
        end
        bad_last = 0;
        for (int i = 0; i < 64 && i < n_out; i++) begin
            if (out_last[i] !== (i == 63)) bad_last++;
        end
        if (bad_last !== 0) begin $display("FAIL bp_last_placement: %0d words with wrong last, want 0", bad_last); n_err++; end
        n_vec++;
        if (stall_viol !== 0) begin $display("FAIL bp_stall_stable: %0d changes while stalled, want 0", stall_viol); n_err++; end
        n_vec++;
        if (n_done !== 1) begin $display("FAIL bp_done_count: got %0d want 1", n_done); n_err++; end
        n_vec++;
        if (extra_mvalid !== 0) begin $display("FAIL bp_extra_words: got %0d want 0", extra_mvalid); n_err++; end
        n_vec++;
        if (sat_cnt !== 16'(nsat)) begin $display("FAIL bp_sat_cnt: got %0d want %0d", sat_cnt, nsat); n_err++; end
        n_vec++;
    endtask

    task automatic test_zero_len_ignored_start();
        int first_done, n_d, any_sr, any_mv, any_busy;
        logic [TOUT*DW-1:0] e [3];
        first_done = -1; n_d = 0; any_sr = 0; any_mv = 0; any_busy = 0;
        start_job(3, 1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = rnd_beat();
            m_ready = 1'b1;
            #1;
            if (done) begin n_d++; if (first_done < 0) first_done = i; end
            if (s_ready) any_sr++;
            if (m_valid) any_mv++;
            if (busy) any_busy++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        if (first_done !== 0 || n_d !== 1) begin
            $display("FAIL zero_done: first at %0d count %0d want 0 and 1", first_done, n_d); n_err++;
        end
        n_vec++;
        if (any_sr !== 0 || any_mv !== 0 || any_busy !== 0) begin
            $display("FAIL zero_quiet: s_ready %0d m_valid %0d busy %0d cycles want 0", any_sr, any_mv, any_busy); n_err++;
        end
        n_vec++;
        // A second start while running must not disturb config or counters.
        in_beats[0] = pk(7, -7, 6, -6, 2, -2, 1000, -1000);
        in_beats[1] = pk(1, 2, 3, -1, -2, -3, -4, 5);
        in_beats[2] = pk(400, -400, 0, 0, 0, 0, 0, 0);
        e[0] = pw(2, -2, 2, -1, 1, 0, 250, -250);
        e[1] = pw(0, 1, 1, 0, 0, -1, -1, 1);
        e[2] = pw(100, -100, 0, 0, 0, 0, 0, 0);
        start_job(2, 1'b0, 1'b0, 3);
        cfg_shift = 5'd9; cfg_relu_en = 1'b1; cfg_dw8 = 1'b1; cfg_pix_num = 16'd100;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        run_stream(3, 100, 100, 60);
        if (n_out !== 3) begin $display("FAIL ign_count: got %0d want 3", n_out); n_err++; end
        n_vec++;
        for (int i = 0; i < 3; i++) begin
            if (out_words[i] !== e[i]) begin $display("FAIL ign_word%0d: got %h want %h", i, out_words[i], e[i]); n_err++; end
            n_vec++;
        end
        if (out_last[0] !== 1'b0 || out_last[1] !== 1'b0 || out_last[2] !== 1'b1) begin
            $display("FAIL ign_last: got %b%b%b want 001", out_last[0], out_last[1], out_last[2]); n_err++;
        end
        n_vec++;
        if (n_done !== 1) begin $display("FAIL ign_done: got %0d want 1", n_done); n_err++; end
        n_vec++;
    endtask

    task automatic test_reset_mid_job();
        int acc, guard, n_d;
        logic [TOUT*DW-1:0] e [3];
        acc = 0; guard = 0; n_d = 0;
        start_job(0, 1'b0, 1'b1, 10);
        while (acc < 4 && guard < 20) begin
            s_valid = 1'b1;
            s_data  = pk(1000, 0, 0, 0, 0, 0, 0, 0);
            m_ready = 1'b1;
            #1;
            if (s_ready) acc++;
            @(posedge clk); #1;
            guard++;
        end
        s_valid = 1'b0;
        // Beats accepted on four consecutive edges: three have already reached S2.
        #1;
        if (sat_cnt !== 16'd3) begin $display("FAIL rstjob_pre_sat: got %0d want 3", sat_cnt); n_err++; end
        n_vec++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || s_ready !== 1'b0) begin
            $display("FAIL rstjob_flags: m_valid/busy/done/s_ready got %b%b%b%b want 0000", m_valid, busy, done, s_ready); n_err++;
        end
        n_vec++;
        if (sat_cnt !== 16'd0) begin $display("FAIL rstjob_sat: got %0d want 0", sat_cnt); n_err++; end
        n_vec++;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (done || m_valid) n_d++;
            @(posedge clk); #1;
        end
        if (n_d !== 0) begin $display("FAIL rstjob_quiet: %0d cycles with done/m_valid want 0", n_d); n_err++; end
        n_vec++;
        in_beats[0] = pk(10, 20, 30, 40, -10, -20, -30, -40);
        in_beats[1] = pk(1, 1, 1, 1, 1, 1, 1, 1);
        in_beats[2] = pk(-1, -1, -1, -1, 300, -300, 0, 0);
        e[0] = pw(10, 20, 30, 40, -10, -20, -30, -40);
        e[1] = pw(1, 1, 1, 1, 1, 1, 1, 1);
        e[2] = pw(-1, -1, -1, -1, 127, -128, 0, 0);
        start_job(0, 1'b0, 1'b1, 3);
        run_stream(3, 100, 100, 60);
        if (n_out !== 3 || n_done !== 1) begin
            $display("FAIL rstjob_rerun: words %0d done %0d want 3 and 1", n_out, n_done); n_err++;
        end
        n_vec++;
        for (int i = 0; i < 3; i++) begin
            if (out_words[i] !== e[i]) begin $display("FAIL rstjob_word%0d: got %h want %h", i, out_words[i], e[i]); n_err++; end
            n_vec++;
        end
        if (sat_cnt !== 16'd1) begin $display("FAIL rstjob_rerun_sat: got %0d want 1", sat_cnt); n_err++; end
        n_vec++;
    endtask

    task automatic test_full_rate();
        int nsat, nbad;
        gen_rand(197, 3, 1'b1, 1'b0, nsat);
        start_job(3, 1'b1, 1'b0, 197);
        run_stream(197, 100, 100, 400);
        if (n_sent !== 197 || sready_gap !== 0) begin
            $display("FAIL fr_s_ready: accepted %0d gaps %0d want 197 and 0", n_sent, sready_gap); n_err++;
        end
        n_vec++;
        // Loop cycle 0 is the first RUN cycle; beats then go in back to back.
        if (last_acc_cyc !== 196) begin $display("FAIL fr_last_accept: cycle %0d want 196", last_acc_cyc); n_err++; end
        n_vec++;
        // Two register stages: a beat accepted in cycle n is on m_data in cycle n+2.
        if (last_cyc !== 198) begin $display("FAIL fr_last_word_cycle: cycle %0d want 198", last_cyc); n_err++; end
        n_vec++;
        if (n_out !== 197) begin $display("FAIL fr_count: got %0d want 197", n_out); n_err++; end
        n_vec++;
        nbad = 0;
        for (int i = 0; i < 197 && i < n_out; i++) begin
            if (out_words[i] !== exp_words[i]) begin
                if (nbad == 0) $display("FAIL fr_word%0d: got %h want %h", i, out_words[i], exp_words[i]);
                nbad++;
            end
        end
        if (nbad !== 0) begin $display("FAIL fr_words: %0d bad words want 0", nbad); n_err++; end
        n_vec++;
        if (sat_cnt !== 16'(nsat) || n_done !== 1) begin
            $display("FAIL fr_end: sat %0d done %0d want %0d and 1", sat_cnt, n_done, nsat); n_err++;
        end
        n_vec++;
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_sat_relu();
        test_backpressure();
        test_zero_len_ignored_start();
        test_reset_mid_job();
        test_full_rate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
